// File: rtl/lzd_shift_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzd_shift_encoder_pkg
// Purpose  : Shared FPU constants and helpers for the leading-zero detector.
//            Holds the nibble group width and the group-count function.
// Revision : 1.0 - initial release
// ============================================================================
package lzd_shift_encoder_pkg;

    // Bits per leading-zero group.
    localparam int LZD_GRP = 4;

    // Per-nibble leading-zero result.
    typedef struct packed {
        logic       zero;
        logic [1:0] cnt;
    } lzd_grp_t;

    // Number of nibble groups after appending at least one padding bit.
    function automatic int NG(input int swr);
        return (swr + 1 + LZD_GRP - 1) / LZD_GRP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzd_shift_encoder_group4.sv
`default_nettype none
// ============================================================================
// Module   : lzd_group4
// Purpose  : Combinational leading-zero count of one 4-bit nibble.
//            o_cnt is don't-care when o_zero is set.
// Revision : 1.0 - initial release
// ============================================================================
module lzd_group4 (
    input  logic [3:0] i_nib,
    output logic       o_zero,
    output logic [1:0] o_cnt
);

    // Priority decode of the first set bit from the MSB side.
    always_comb begin
        o_zero = ~|i_nib;
        o_cnt  = 2'd0;
        casez (i_nib)
            4'b1???: o_cnt = 2'd0;
            4'b01??: o_cnt = 2'd1;
            4'b001?: o_cnt = 2'd2;
            4'b0001: o_cnt = 2'd3;
            default: o_cnt = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lzd_shift_encoder.sv
`default_nettype none
// ============================================================================
// Module   : lzd_shift_encoder
// Purpose  : Two-stage pipelined leading-zero detector with valid/ready flow
//            control, producing the normalization left-shift amount.
// Revision : 1.0 - initial release
// ============================================================================
module lzd_shift_encoder
    import lzd_shift_encoder_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    input  logic [SWR-1:0] S_i,
    output logic           ready_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [EWR-1:0] lz_count_o,
    output logic           zero_o
);

    localparam int c_ng    = NG(SWR);
    localparam int c_ext_w = c_ng * LZD_GRP;
    localparam int c_pad_w = c_ext_w - SWR;

    // The padding ones guarantee a non-zero nibble, so an all-zero input
    // counts exactly SWR leading zeros.
    logic [c_ext_w-1:0]       w_ext;
    lzd_grp_t [c_ng-1:0]      w_grp;
    logic                     w_en1;
    logic                     w_en2;
    logic [EWR-1:0]           w_lz;

    logic                     r_v1;
    logic                     r_zero_s1;
    lzd_grp_t [c_ng-1:0]      r_grp;
    logic                     r_valid_o;
    logic [EWR-1:0]           r_lz;
    logic                     r_zero;

    assign w_ext = {S_i, {c_pad_w{1'b1}}};

    // Group index 0 is the most-significant nibble.
    for (genvar g = 0; g < c_ng; g++) begin : g_grp
        lzd_group4 u_grp (
            .i_nib  (w_ext[c_ext_w-1-LZD_GRP*g -: LZD_GRP]),
            .o_zero (w_grp[g].zero),
            .o_cnt  (w_grp[g].cnt)
        );
    end

    // Stage 2 may advance when empty or when its content is being taken;
    // stage 1 may advance when empty or when stage 2 advances.
    always_comb begin
        w_en2 = ~r_valid_o | ready_i;
        w_en1 = ~r_v1 | w_en2;
    end

    assign ready_o = w_en1;

    // Stage 1: register per-nibble flags/counts and the all-zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_zero_s1 <= 1'b0;
            r_grp     <= '0;
        end else if (w_en1) begin
            r_v1      <= valid_i;
            r_zero_s1 <= ~|S_i;
            r_grp     <= w_grp;
        end
    end

    // Priority-select the first non-zero nibble, scanning so that the
    // most-significant candidate is assigned last and wins.
    always_comb begin
        w_lz = '0;
        for (int g = c_ng - 1; g >= 0; g--) begin
            if (!r_grp[g].zero) begin
                w_lz = EWR'(LZD_GRP * g) + EWR'(r_grp[g].cnt);
            end
        end
    end

    // Stage 2: register the encoded count; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_o <= 1'b0;
            r_lz      <= '0;
            r_zero    <= 1'b0;
        end else if (w_en2) begin
            r_valid_o <= r_v1;
            r_lz      <= w_lz;
            r_zero    <= r_zero_s1;
        end
    end

    assign valid_o    = r_valid_o;
    assign lz_count_o = r_lz;
    assign zero_o     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_lzd_shift_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzd_shift_encoder
// Purpose  : Self-checking bench: directed vectors, stall and reset
//            sequences, and randomized valid/ready traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzd_shift_encoder;

    localparam int SWR = 26;
    localparam int EWR = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_i;
    logic [SWR-1:0] S_i;
    logic           ready_o;
    logic           valid_o;
    logic           ready_i;
    logic [EWR-1:0] lz_count_o;
    logic           zero_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [SWR-1:0] s;
        int             lz;
        int             z;
    } vec_t;

    vec_t tbl [6];
    int   exp_q [$];

    always #5 clk = ~clk;

    lzd_shift_encoder #(.SWR(SWR), .EWR(EWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .S_i        (S_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .lz_count_o (lz_count_o),
        .zero_o     (zero_o)
    );

    // Reference: walk from the MSB counting zeros until the first one.
    function automatic int ref_lz(input logic [SWR-1:0] s);
        int n = 0;
        for (int i = SWR - 1; i >= 0; i--) begin
            if (s[i]) break;
            n++;
        end
        return n;
    endfunction

    // Packs {zero, count} so one queue entry holds a full expected result.
    function automatic int ref_pack(input logic [SWR-1:0] s);
        return ((s == '0) ? 256 : 0) + ref_lz(s);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_random(input int cycles);
        int  hold_lz;
        bit  hold_chk;
        logic [SWR-1:0] v;
        hold_chk = 1'b0;
        hold_lz  = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            // Previous cycle was a stall with data: output must be unchanged.
            if (hold_chk) begin
                chk("stall_valid", int'(valid_o), 1);
                chk("stall_hold", int'({zero_o, 3'b000, lz_count_o}), hold_lz);
            end
            v = SWR'($urandom) >> $urandom_range(0, SWR);
            if ($urandom_range(0, 15) == 0) v = '0;
            valid_i = ($urandom_range(0, 3) != 0);
            S_i     = v;
            ready_i = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_ready", int'(ready_o), (exp_q.size() == 2 && !ready_i) ? 0 : 1);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) chk("rnd_spurious", 1, 0);
                else chk("rnd_out", int'({zero_o, 3'b000, lz_count_o}), exp_q.pop_front());
            end
            hold_chk = valid_o && !ready_i;
            hold_lz  = int'({zero_o, 3'b000, lz_count_o});
            if (valid_i && ready_o) exp_q.push_back(ref_pack(v));
        end
        // Drain with a bounded budget.
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            #1;
            if (valid_o) chk("drain_out", int'({zero_o, 3'b000, lz_count_o}), exp_q.pop_front());
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{26'h2000000, 0, 0};
        tbl[1] = '{26'h0010000, 9, 0};
        tbl[2] = '{26'h0000001, 25, 0};
        tbl[3] = '{26'h0000000, 26, 1};
        tbl[4] = '{26'h3ffffff, 0, 0};
        tbl[5] = '{26'h0000010, 21, 0};

        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        S_i     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_lz", int'(lz_count_o), 0);
        chk("rst_zero", int'(zero_o), 0);
        chk("rst_ready", int'(ready_o), 1);

        // Directed table, one vector at a time, exact 2-cycle latency.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            S_i     = tbl[i].s;
            ready_i = 1'b1;
            @(negedge clk);
            valid_i = 1'b0;
            chk("lat_early", int'(valid_o), 0);
            @(negedge clk);
            chk("tbl_valid", int'(valid_o), 1);
            chk("tbl_lz", int'(lz_count_o), tbl[i].lz);
            chk("tbl_zero", int'(zero_o), tbl[i].z);
            chk("tbl_model", ref_lz(tbl[i].s), tbl[i].lz);
        end
        @(negedge clk);
        chk("tbl_idle", int'(valid_o), 0);

        // Full stall: two accepted, third blocked until ready_i rises.
        ready_i = 1'b0;
        valid_i = 1'b1;
        S_i     = 26'h1000000;
        #1 chk("st_rdy1", int'(ready_o), 1);
        @(negedge clk);
        S_i = 26'h0000100;
        #1 chk("st_rdy2", int'(ready_o), 1);
        @(negedge clk);
        S_i = 26'h0000002;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_rdy_low", int'(ready_o), 0);
            chk("st_valid", int'(valid_o), 1);
            chk("st_lz_hold", int'(lz_count_o), 1);
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        chk("st_rdy_rise", int'(ready_o), 1);
        chk("st_out1", int'(lz_count_o), 1);
        @(negedge clk);
        valid_i = 1'b0;
        chk("st_v2", int'(valid_o), 1);
        chk("st_out2", int'(lz_count_o), 17);
        @(negedge clk);
        chk("st_v3", int'(valid_o), 1);
        chk("st_out3", int'(lz_count_o), 24);
        @(negedge clk);
        chk("st_empty", int'(valid_o), 0);

        // Reset with both stages full discards everything.
        ready_i = 1'b0;
        valid_i = 1'b1;
        S_i     = 26'h0000400;
        @(negedge clk);
        S_i = 26'h0008000;
        @(negedge clk);
        #1 chk("rm_full", int'(ready_o), 0);
        valid_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_valid_o", int'(valid_o), 0);
        chk("rm_lz", int'(lz_count_o), 0);
        chk("rm_ready", int'(ready_o), 1);
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rm_no_ghost", int'(valid_o), 0);
        end

        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
